// File: rtl/md_bus_resolver_if.sv
// Bus-side bundle for md_bus_resolver: driver data/release vectors, clear strobe,
// and the registered resolved-bus and contention outputs.
interface md_bus_resolver_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
);
  logic [N*WIDTH-1:0] drv_o;
  logic [N*WIDTH-1:0] drv_d;
  logic               clr;
  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   bus_driven;
  logic               contention;
  logic [CNT_W-1:0]   contention_cnt;
  logic               contention_sticky;

  modport master (
    output drv_o, drv_d, clr,
    input  bus, bus_driven, contention, contention_cnt, contention_sticky
  );

  modport slave (
    input  drv_o, drv_d, clr,
    output bus, bus_driven, contention, contention_cnt, contention_sticky
  );
endinterface

// File: rtl/md_bus_resolver.sv
// Registered N-driver shared-bus resolver: wired-OR/AND merge, keeper/pull/decay
// handling of undriven bits, and contention detection with saturating count.
module md_bus_resolver #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      N            = 4,
  parameter int unsigned      RESOLVE      = 0,
  parameter int unsigned      MODE         = 0,
  parameter logic [WIDTH-1:0] PULL_VALUE   = '1,
  parameter int unsigned      DECAY_CYCLES = 8,
  parameter int unsigned      CNT_W        = 8
) (
  input logic               MCLK,
  input logic               reset,
  md_bus_resolver_if.slave  bus_if
);

  localparam int unsigned     DW        = $clog2(DECAY_CYCLES + 1);
  localparam logic [DW-1:0]   DECAY_MAX = DW'(DECAY_CYCLES);

  logic [WIDTH-1:0] has0_c, has1_c;
  logic [WIDTH-1:0] driven_c, contend_c, bus_next;
  logic             contention_c;
  logic [DW-1:0]    dcnt_next [WIDTH];

  logic [WIDTH-1:0] bus_q, driven_q;
  logic             cont_q, sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    dcnt_q [WIDTH];

  always_comb begin
    has0_c    = '0;
    has1_c    = '0;
    driven_c  = '0;
    contend_c = '0;
    bus_next  = bus_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      dcnt_next[i] = dcnt_q[i];
      for (int unsigned k = 0; k < N; k++) begin
        if (!bus_if.drv_d[k*WIDTH + i]) begin
          if (bus_if.drv_o[k*WIDTH + i]) has1_c[i] = 1'b1;
          else                           has0_c[i] = 1'b1;
        end
      end
      driven_c[i]  = has0_c[i] | has1_c[i];
      contend_c[i] = has0_c[i] & has1_c[i];
      if (driven_c[i]) begin
        // OR over actives is "any 1"; AND over actives is "no 0"
        bus_next[i]  = (RESOLVE == 0) ? has1_c[i] : ~has0_c[i];
        dcnt_next[i] = '0;
      end else if (MODE == 1) begin
        bus_next[i] = PULL_VALUE[i];
      end else if (MODE == 2) begin
        if (dcnt_q[i] < DECAY_MAX) dcnt_next[i] = dcnt_q[i] + DW'(1);
        if (dcnt_next[i] == DECAY_MAX) bus_next[i] = PULL_VALUE[i];
      end
    end
    contention_c = |contend_c;
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      bus_q    <= PULL_VALUE;
      driven_q <= '0;
      cont_q   <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) dcnt_q[i] <= DECAY_MAX;
    end else begin
      bus_q    <= bus_next;
      driven_q <= driven_c;
      cont_q   <= contention_c;
      for (int unsigned i = 0; i < WIDTH; i++) dcnt_q[i] <= dcnt_next[i];
      // A contention event in the clear cycle is counted after the clear
      if (bus_if.clr) begin
        cnt_q    <= contention_c ? CNT_W'(1) : '0;
        sticky_q <= contention_c;
      end else if (contention_c) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        sticky_q <= 1'b1;
      end
    end
  end

  assign bus_if.bus               = bus_q;
  assign bus_if.bus_driven        = driven_q;
  assign bus_if.contention        = cont_q;
  assign bus_if.contention_cnt    = cnt_q;
  assign bus_if.contention_sticky = sticky_q;

endmodule

// File: tb/tb_md_bus_resolver.sv
// Directed bench for md_bus_resolver over four parameter sets sharing one stimulus.
module tb_md_bus_resolver;
  logic        MCLK = 1'b0;
  logic        reset;
  logic [31:0] d_o, d_d;
  logic        clr;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 MCLK = ~MCLK;

  // u0: keeper, OR, CNT_W 2; u1: decay 4; u2: keeper, AND; u3: N=1, decay 1
  md_bus_resolver_if #(.WIDTH(16), .N(2), .CNT_W(2)) if0 ();
  md_bus_resolver_if #(.WIDTH(16), .N(2), .CNT_W(8)) if1 ();
  md_bus_resolver_if #(.WIDTH(16), .N(2), .CNT_W(8)) if2 ();
  md_bus_resolver_if #(.WIDTH(16), .N(1), .CNT_W(8)) if3 ();

  assign if0.drv_o = d_o;  assign if0.drv_d = d_d;  assign if0.clr = clr;
  assign if1.drv_o = d_o;  assign if1.drv_d = d_d;  assign if1.clr = clr;
  assign if2.drv_o = d_o;  assign if2.drv_d = d_d;  assign if2.clr = clr;
  assign if3.drv_o = d_o[15:0];  assign if3.drv_d = d_d[15:0];  assign if3.clr = clr;

  md_bus_resolver #(.WIDTH(16), .N(2), .RESOLVE(0), .MODE(0), .PULL_VALUE(16'hFFFF),
                    .DECAY_CYCLES(8), .CNT_W(2))
    u0 (.MCLK(MCLK), .reset(reset), .bus_if(if0.slave));
  md_bus_resolver #(.WIDTH(16), .N(2), .RESOLVE(0), .MODE(2), .PULL_VALUE(16'hFFFF),
                    .DECAY_CYCLES(4), .CNT_W(8))
    u1 (.MCLK(MCLK), .reset(reset), .bus_if(if1.slave));
  md_bus_resolver #(.WIDTH(16), .N(2), .RESOLVE(1), .MODE(0), .PULL_VALUE(16'hFFFF),
                    .DECAY_CYCLES(8), .CNT_W(8))
    u2 (.MCLK(MCLK), .reset(reset), .bus_if(if2.slave));
  md_bus_resolver #(.WIDTH(16), .N(1), .RESOLVE(0), .MODE(2), .PULL_VALUE(16'hFFFF),
                    .DECAY_CYCLES(1), .CNT_W(8))
    u3 (.MCLK(MCLK), .reset(reset), .bus_if(if3.slave));

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic drive(input logic [15:0] o0, input logic [15:0] m0,
                       input logic [15:0] o1, input logic [15:0] m1);
    d_o = {o1, o0};
    d_d = {m1, m0};
  endtask

  task automatic release_all();
    drive(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF);
  endtask

  task automatic contend();
    drive(16'h00F0, 16'hFF00, 16'h0F0F, 16'h0000);
  endtask

  task automatic test_reset();
    reset = 1'b1; clr = 1'b0; release_all();
    step(); step();
    reset = 1'b0;
    n_checks++; if (if0.bus !== 16'hFFFF) $display("FAIL rst_bus: got %h want %h", if0.bus, 16'hFFFF); else n_pass++;
    n_checks++; if (if0.bus_driven !== 16'h0000) $display("FAIL rst_driven: got %h want %h", if0.bus_driven, 16'h0000); else n_pass++;
    n_checks++; if (if0.contention !== 1'b0) $display("FAIL rst_cont: got %b want 0", if0.contention); else n_pass++;
    n_checks++; if (if0.contention_cnt !== 2'd0) $display("FAIL rst_cnt: got %0d want 0", if0.contention_cnt); else n_pass++;
    n_checks++; if (if0.contention_sticky !== 1'b0) $display("FAIL rst_sticky: got %b want 0", if0.contention_sticky); else n_pass++;
    n_checks++; if (if1.bus !== 16'hFFFF) $display("FAIL rst_bus_decay: got %h want %h", if1.bus, 16'hFFFF); else n_pass++;
  endtask

  task automatic test_keeper();
    drive(16'h1234, 16'h0000, 16'h0000, 16'hFFFF);
    step();
    n_checks++; if (if0.bus !== 16'h1234) $display("FAIL keep_load: got %h want %h", if0.bus, 16'h1234); else n_pass++;
    n_checks++; if (if0.bus_driven !== 16'hFFFF) $display("FAIL keep_driven: got %h want %h", if0.bus_driven, 16'hFFFF); else n_pass++;
    release_all();
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++; if (if0.bus !== 16'h1234) $display("FAIL keep_hold[%0d]: got %h want %h", c, if0.bus, 16'h1234); else n_pass++;
      n_checks++; if (if0.bus_driven !== 16'h0000) $display("FAIL keep_undriven[%0d]: got %h want %h", c, if0.bus_driven, 16'h0000); else n_pass++;
    end
  endtask

  task automatic test_decay();
    logic [15:0] exp;
    drive(16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    step();
    n_checks++; if (if1.bus !== 16'h0000) $display("FAIL decay_load: got %h want %h", if1.bus, 16'h0000); else n_pass++;
    release_all();
    for (int c = 1; c <= 4; c++) begin
      step();
      exp = (c == 4) ? 16'hFFFF : 16'h0000;
      n_checks++; if (if1.bus !== exp) $display("FAIL decay_seq[%0d]: got %h want %h", c, if1.bus, exp); else n_pass++;
      if (c == 1) begin
        n_checks++; if (if3.bus !== 16'hFFFF) $display("FAIL decay1_pull: got %h want %h", if3.bus, 16'hFFFF); else n_pass++;
      end
    end
    drive(16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    step();
    release_all();
    step();
    drive(16'h00FF, 16'h0000, 16'h0000, 16'hFFFF);
    step();
    n_checks++; if (if1.bus !== 16'h00FF) $display("FAIL redrive_load: got %h want %h", if1.bus, 16'h00FF); else n_pass++;
    release_all();
    for (int c = 1; c <= 4; c++) begin
      step();
      exp = (c == 4) ? 16'hFFFF : 16'h00FF;
      n_checks++; if (if1.bus !== exp) $display("FAIL redrive_seq[%0d]: got %h want %h", c, if1.bus, exp); else n_pass++;
    end
  endtask

  task automatic test_resolve();
    contend();
    step();
    n_checks++; if (if0.bus !== 16'h0FFF) $display("FAIL res_or: got %h want %h", if0.bus, 16'h0FFF); else n_pass++;
    n_checks++; if (if2.bus !== 16'h0F00) $display("FAIL res_and: got %h want %h", if2.bus, 16'h0F00); else n_pass++;
    n_checks++; if (if0.contention !== 1'b1) $display("FAIL res_or_cont: got %b want 1", if0.contention); else n_pass++;
    n_checks++; if (if2.contention !== 1'b1) $display("FAIL res_and_cont: got %b want 1", if2.contention); else n_pass++;
    n_checks++; if (if3.bus !== 16'hFFF0) $display("FAIL n1_bus: got %h want %h", if3.bus, 16'hFFF0); else n_pass++;
    n_checks++; if (if3.contention !== 1'b0) $display("FAIL n1_cont: got %b want 0", if3.contention); else n_pass++;
  endtask

  task automatic test_count();
    logic [1:0] exp;
    release_all(); clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++; if (if0.contention_cnt !== 2'd0) $display("FAIL cnt_clr0: got %0d want 0", if0.contention_cnt); else n_pass++;
    contend();
    for (int c = 1; c <= 5; c++) begin
      step();
      exp = (c >= 3) ? 2'd3 : 2'(c);
      n_checks++; if (if0.contention_cnt !== exp) $display("FAIL cnt_sat[%0d]: got %0d want %0d", c, if0.contention_cnt, exp); else n_pass++;
    end
    n_checks++; if (if0.contention_sticky !== 1'b1) $display("FAIL cnt_sticky: got %b want 1", if0.contention_sticky); else n_pass++;
    release_all(); clr = 1'b1;
    step();
    n_checks++; if (if0.contention_cnt !== 2'd0) $display("FAIL clr_cnt: got %0d want 0", if0.contention_cnt); else n_pass++;
    n_checks++; if (if0.contention_sticky !== 1'b0) $display("FAIL clr_sticky: got %b want 0", if0.contention_sticky); else n_pass++;
    contend();
    step();
    clr = 1'b0;
    n_checks++; if (if0.contention_cnt !== 2'd1) $display("FAIL clrc_cnt: got %0d want 1", if0.contention_cnt); else n_pass++;
    n_checks++; if (if0.contention_sticky !== 1'b1) $display("FAIL clrc_sticky: got %b want 1", if0.contention_sticky); else n_pass++;
  endtask

  task automatic test_equal();
    drive(16'hA5A5, 16'h0000, 16'hA5A5, 16'h0000);
    step();
    n_checks++; if (if0.bus !== 16'hA5A5) $display("FAIL eq_bus: got %h want %h", if0.bus, 16'hA5A5); else n_pass++;
    n_checks++; if (if2.bus !== 16'hA5A5) $display("FAIL eq_bus_and: got %h want %h", if2.bus, 16'hA5A5); else n_pass++;
    n_checks++; if (if0.contention !== 1'b0) $display("FAIL eq_cont: got %b want 0", if0.contention); else n_pass++;
    n_checks++; if (if0.contention_cnt !== 2'd1) $display("FAIL eq_cnt: got %0d want 1", if0.contention_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    contend();
    step();
    n_checks++; if (if0.contention_cnt !== 2'd2) $display("FAIL mid_pre_cnt: got %0d want 2", if0.contention_cnt); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (if0.bus !== 16'hFFFF) $display("FAIL mid_bus: got %h want %h", if0.bus, 16'hFFFF); else n_pass++;
    n_checks++; if (if0.bus_driven !== 16'h0000) $display("FAIL mid_driven: got %h want %h", if0.bus_driven, 16'h0000); else n_pass++;
    n_checks++; if (if0.contention_cnt !== 2'd0) $display("FAIL mid_cnt: got %0d want 0", if0.contention_cnt); else n_pass++;
    n_checks++; if (if0.contention_sticky !== 1'b0) $display("FAIL mid_sticky: got %b want 0", if0.contention_sticky); else n_pass++;
    n_checks++; if (if0.contention !== 1'b0) $display("FAIL mid_cont: got %b want 0", if0.contention); else n_pass++;
    release_all();
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++; if (if1.bus !== 16'hFFFF) $display("FAIL post_rst_decay[%0d]: got %h want %h", c, if1.bus, 16'hFFFF); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_keeper();
    test_decay();
    test_resolve();
    test_count();
    test_equal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
